// File: rtl/pipeline_pkg.sv
// Shared definitions for the 5-stage pipeline hazard/stall controller:
// FSM encoding, stage indices and default widths.
package pipeline_pkg;

    localparam int REG_W_DEF = 5;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DMISS  = 2'd1,
        SQUASH = 2'd2
    } state_t;

    // Bit positions in the packed we/flush control vectors
    localparam int STG_PC     = 0;
    localparam int STG_IF_ID  = 1;
    localparam int STG_ID_EX  = 2;
    localparam int STG_EX_MEM = 3;
    localparam int STG_MEM_WB = 4;
    localparam int NUM_STG    = 5;

endpackage

// File: rtl/pipeline_ctrl_mdu_busy_counter.sv
// MDU occupancy counter: loads MDU_LAT on start, counts down to zero,
// busy while nonzero.
module mdu_busy_counter #(
    parameter int MDU_LAT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic busy
);

    localparam int CW = $clog2(MDU_LAT + 1);

    logic [CW-1:0] mdu_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            mdu_cnt <= '0;
        end else if (load) begin
            mdu_cnt <= CW'(MDU_LAT);
        end else if (mdu_cnt != '0) begin
            mdu_cnt <= mdu_cnt - CW'(1);
        end
    end

    assign busy = (mdu_cnt != '0);

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and stall controller for a 5-stage MIPS pipeline.
// Optional stall statistics counters enabled with PIPELINE_CTRL_STATS_EN.
module pipeline_ctrl
    import pipeline_pkg::*;
#(
    parameter int REG_W   = REG_W_DEF,
    parameter int MDU_LAT = 4
`ifdef PIPELINE_CTRL_STATS_EN
   ,parameter int CNT_W   = 32
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_mdu_use,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_branch_taken,
    input  logic             mdu_start,
    input  logic             mem_access,
    input  logic             dcache_ready,
    input  logic             icache_ready,
    output logic             pc_we,
    output logic             if_id_we,
    output logic             id_ex_we,
    output logic             ex_mem_we,
    output logic             mem_wb_we,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             mem_wb_flush,
    output logic             mdu_busy
`ifdef PIPELINE_CTRL_STATS_EN
   ,output logic [CNT_W-1:0] stall_dmiss_cnt,
    output logic [CNT_W-1:0] stall_hazard_cnt,
    output logic [CNT_W-1:0] flush_branch_cnt
`endif
);

    state_t             state, state_nxt;
    logic               busy;
    logic               load_use, mdu_stall, imiss, dmiss;
    logic [NUM_STG-1:0] we, flush;

    assign load_use  = ex_memread && (ex_rd != '0) && ((ex_rd == id_rs) || (ex_rd == id_rt));
    assign mdu_stall = id_mdu_use && busy;
    assign imiss     = !icache_ready;
    assign dmiss     = mem_access && !dcache_ready;

    // A frozen EX re-presents mdu_start, so it only counts once the miss clears
    mdu_busy_counter #(.MDU_LAT(MDU_LAT)) u_mdu (
        .clk   (clk),
        .reset (reset),
        .load  (mdu_start && !dmiss),
        .busy  (busy)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= RUN;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN: begin
                if (dmiss)                        state_nxt = DMISS;
                else if (ex_branch_taken && imiss) state_nxt = SQUASH;
            end
            DMISS:   if (dcache_ready) state_nxt = RUN;
            SQUASH:  if (icache_ready) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    // NOTE: every output gets a default first, so no path through the block can infer a latch.
    always_comb begin
        we    = '1;
        flush = '0;
        if (reset) begin
            we    = '0;
            flush = '1;
            flush[STG_PC] = 1'b0;
        end else if (dmiss) begin
            we                = '0;
            we[STG_MEM_WB]    = 1'b1;
            flush[STG_MEM_WB] = 1'b1;
        end else if (ex_branch_taken) begin
            flush[STG_IF_ID] = 1'b1;
            flush[STG_ID_EX] = 1'b1;
        end else if (load_use || mdu_stall) begin
            we[STG_PC]       = 1'b0;
            we[STG_IF_ID]    = 1'b0;
            flush[STG_ID_EX] = 1'b1;
        end else if (state == SQUASH) begin
            // Wrong-path fetch is dropped even on the cycle it returns
            we[STG_PC]       = icache_ready;
            flush[STG_IF_ID] = 1'b1;
        end else if (imiss) begin
            we[STG_PC]       = 1'b0;
            flush[STG_IF_ID] = 1'b1;
        end
    end

    assign pc_we        = we[STG_PC];
    assign if_id_we     = we[STG_IF_ID];
    assign id_ex_we     = we[STG_ID_EX];
    assign ex_mem_we    = we[STG_EX_MEM];
    assign mem_wb_we    = we[STG_MEM_WB];
    assign if_id_flush  = flush[STG_IF_ID];
    assign id_ex_flush  = flush[STG_ID_EX];
    assign ex_mem_flush = flush[STG_EX_MEM];
    assign mem_wb_flush = flush[STG_MEM_WB];
    assign mdu_busy     = busy && !reset;

`ifdef PIPELINE_CTRL_STATS_EN
    logic win_dmiss, win_branch, win_hazard;

    assign win_dmiss  = dmiss;
    assign win_branch = !dmiss && ex_branch_taken;
    assign win_hazard = !dmiss && !ex_branch_taken && (load_use || mdu_stall);

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_dmiss_cnt  <= '0;
            stall_hazard_cnt <= '0;
            flush_branch_cnt <= '0;
        end else begin
            if (win_dmiss)  stall_dmiss_cnt  <= stall_dmiss_cnt  + CNT_W'(1);
            if (win_hazard) stall_hazard_cnt <= stall_hazard_cnt + CNT_W'(1);
            if (win_branch) flush_branch_cnt <= flush_branch_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl; control outputs are
// compared as a packed {we[pc..mem_wb], flush[if_id..mem_wb]} vector.
module tb_pipeline_ctrl;
    import pipeline_pkg::*;

    localparam int REG_W = 5;

    // {pc, if_id, id_ex, ex_mem, mem_wb we} , {if_id, id_ex, ex_mem, mem_wb flush}
    localparam logic [8:0] C_RST    = 9'b00000_1111;
    localparam logic [8:0] C_FLOW   = 9'b11111_0000;
    localparam logic [8:0] C_STALL  = 9'b00111_0100;
    localparam logic [8:0] C_DMISS  = 9'b00001_0001;
    localparam logic [8:0] C_BRANCH = 9'b11111_1100;
    localparam logic [8:0] C_IMISS  = 9'b01111_1000;
    localparam logic [8:0] C_SQ_RDY = 9'b11111_1000;

    logic             clk = 1'b0;
    logic             reset;
    logic [REG_W-1:0] id_rs, id_rt, ex_rd;
    logic             id_mdu_use, ex_memread, ex_branch_taken, mdu_start;
    logic             mem_access, dcache_ready, icache_ready;
    logic             pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
    logic             if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
    logic             mdu_busy;
`ifdef PIPELINE_CTRL_STATS_EN
    logic [31:0]      stall_dmiss_cnt, stall_hazard_cnt, flush_branch_cnt;
`endif
    logic [8:0]       ctl;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(.REG_W(REG_W), .MDU_LAT(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_mdu_use      (id_mdu_use),
        .ex_memread      (ex_memread),
        .ex_rd           (ex_rd),
        .ex_branch_taken (ex_branch_taken),
        .mdu_start       (mdu_start),
        .mem_access      (mem_access),
        .dcache_ready    (dcache_ready),
        .icache_ready    (icache_ready),
        .pc_we           (pc_we),
        .if_id_we        (if_id_we),
        .id_ex_we        (id_ex_we),
        .ex_mem_we       (ex_mem_we),
        .mem_wb_we       (mem_wb_we),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .ex_mem_flush    (ex_mem_flush),
        .mem_wb_flush    (mem_wb_flush),
        .mdu_busy        (mdu_busy)
`ifdef PIPELINE_CTRL_STATS_EN
       ,.stall_dmiss_cnt (stall_dmiss_cnt),
        .stall_hazard_cnt(stall_hazard_cnt),
        .flush_branch_cnt(flush_branch_cnt)
`endif
    );

    assign ctl = {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
                  if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to the next vector slot: inputs change at negedge, checked 1 time unit later
    task automatic next_vec();
        @(negedge clk);
        reset           = 1'b0;
        id_rs           = '0;
        id_rt           = '0;
        ex_rd           = '0;
        id_mdu_use      = 1'b0;
        ex_memread      = 1'b0;
        ex_branch_taken = 1'b0;
        mdu_start       = 1'b0;
        mem_access      = 1'b0;
        dcache_ready    = 1'b1;
        icache_ready    = 1'b1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        next_vec(); reset = 1'b1; settle();
        check("reset_ctl", 32'(ctl), 32'(C_RST));
        next_vec(); reset = 1'b1; settle();
        check("reset_busy", 32'(mdu_busy), 32'd0);

        next_vec(); settle();
        check("idle_flow", 32'(ctl), 32'(C_FLOW));
        check("idle_state", 32'(dut.state), 32'(RUN));

        // Load-use on rs, then on rt, then register 0 must not stall
        next_vec(); ex_memread = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; settle();
        check("lu_rs", 32'(ctl), 32'(C_STALL));
        next_vec(); settle();
        check("lu_after", 32'(ctl), 32'(C_FLOW));
        next_vec(); ex_memread = 1'b1; ex_rd = 5'd5; id_rt = 5'd5; id_rs = 5'd6; settle();
        check("lu_rt", 32'(ctl), 32'(C_STALL));
        next_vec(); ex_memread = 1'b1; ex_rd = 5'd0; settle();
        check("lu_r0", 32'(ctl), 32'(C_FLOW));
        next_vec(); ex_memread = 1'b0; ex_rd = 5'd9; id_rs = 5'd9; settle();
        check("no_load", 32'(ctl), 32'(C_FLOW));

        // D-miss for three cycles, with a branch that must be ignored
        next_vec(); mem_access = 1'b1; dcache_ready = 1'b0; settle();
        check("dmiss_1", 32'(ctl), 32'(C_DMISS));
        next_vec(); mem_access = 1'b1; dcache_ready = 1'b0; ex_branch_taken = 1'b1; settle();
        check("dmiss_2_br", 32'(ctl), 32'(C_DMISS));
        check("dmiss_state", 32'(dut.state), 32'(DMISS));
        next_vec(); mem_access = 1'b1; dcache_ready = 1'b0; settle();
        check("dmiss_3", 32'(ctl), 32'(C_DMISS));
        next_vec(); mem_access = 1'b1; settle();
        check("dmiss_done", 32'(ctl), 32'(C_FLOW));
        next_vec(); settle();
        check("dmiss_run", 32'(dut.state), 32'(RUN));

        // Branch overrides a simultaneous load-use
        next_vec(); ex_branch_taken = 1'b1; ex_memread = 1'b1; ex_rd = 5'd3; id_rt = 5'd3; settle();
        check("br_lu", 32'(ctl), 32'(C_BRANCH));

        // I-miss alone
        next_vec(); icache_ready = 1'b0; settle();
        check("imiss", 32'(ctl), 32'(C_IMISS));
        check("imiss_state", 32'(dut.state), 32'(RUN));

        // Branch during I-miss enters SQUASH
        next_vec(); ex_branch_taken = 1'b1; icache_ready = 1'b0; settle();
        check("sq_br", 32'(ctl), 32'(C_BRANCH));
        next_vec(); icache_ready = 1'b0; settle();
        check("sq_state", 32'(dut.state), 32'(SQUASH));
        check("sq_wait1", 32'(ctl), 32'(C_IMISS));
        next_vec(); icache_ready = 1'b0; settle();
        check("sq_wait2", 32'(ctl), 32'(C_IMISS));
        next_vec(); settle();
        check("sq_ready", 32'(ctl), 32'(C_SQ_RDY));
        next_vec(); settle();
        check("sq_exit", 32'(dut.state), 32'(RUN));
        check("sq_flow", 32'(ctl), 32'(C_FLOW));

        // MDU occupancy: four busy cycles stall an MDU user
        next_vec(); mdu_start = 1'b1; settle();
        check("mdu_start", 32'(ctl), 32'(C_FLOW));
        check("mdu_idle", 32'(mdu_busy), 32'd0);
        for (int i = 0; i < 4; i++) begin
            next_vec(); id_mdu_use = 1'b1; settle();
            check($sformatf("mdu_busy_%0d", i), 32'(mdu_busy), 32'd1);
            check($sformatf("mdu_stall_%0d", i), 32'(ctl), 32'(C_STALL));
        end
        next_vec(); id_mdu_use = 1'b1; settle();
        check("mdu_free", 32'(mdu_busy), 32'd0);
        check("mdu_flow", 32'(ctl), 32'(C_FLOW));

        // mdu_start frozen by a D-miss does not load the counter
        next_vec(); mdu_start = 1'b1; mem_access = 1'b1; dcache_ready = 1'b0; settle();
        check("mdu_dmiss", 32'(ctl), 32'(C_DMISS));
        next_vec(); settle();
        check("mdu_ignored", 32'(mdu_busy), 32'd0);

        // Reset during DMISS with the MDU busy
        next_vec(); mdu_start = 1'b1; settle();
        next_vec(); mem_access = 1'b1; dcache_ready = 1'b0; settle();
        check("pre_rst_busy", 32'(mdu_busy), 32'd1);
        next_vec(); reset = 1'b1; mem_access = 1'b1; dcache_ready = 1'b0; settle();
        check("rst_dmiss_ctl", 32'(ctl), 32'(C_RST));
        check("rst_dmiss_busy", 32'(mdu_busy), 32'd0);
        next_vec(); settle();
        check("rst_state", 32'(dut.state), 32'(RUN));
        check("rst_cnt", 32'(dut.u_mdu.mdu_cnt), 32'd0);
        check("rst_flow", 32'(ctl), 32'(C_FLOW));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
